serv_rf_dbg_arb: RTL

//  Arbiter between serv_rf_ram_if (CPU) and the debug module for the serv_rf_ram port pair.

---
 rtl/serv_rf_dbg_arb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/serv_rf_dbg_arb.sv
// Shares the serv_rf_ram ports between the CPU register-file interface and a debug sequencer
// that splits 32-bit debug register reads/writes into RF_WIDTH-wide RAM word accesses.
module serv_rf_dbg_arb #(
    parameter int RF_WIDTH = 8,
    parameter int CSR_REGS = 4,
    parameter int RF_L2D   = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH)
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_halted,
    input  logic [RF_L2D-1:0]   i_cpu_waddr,
    input  logic [RF_WIDTH-1:0] i_cpu_wdata,
    input  logic                i_cpu_wen,
    input  logic [RF_L2D-1:0]   i_cpu_raddr,
    input  logic                i_cpu_ren,
    output logic [RF_WIDTH-1:0] o_cpu_rdata,
    input  logic                i_dbg_req,
    input  logic                i_dbg_we,
    input  logic [5:0]          i_dbg_regnum,
    input  logic [31:0]         i_dbg_wdata,
    output logic                o_dbg_ack,
    output logic                o_dbg_err,
    output logic [31:0]         o_dbg_rdata,
    output logic                o_dbg_busy,
    output logic [RF_L2D-1:0]   o_waddr,
    output logic [RF_WIDTH-1:0] o_wdata,
    output logic                o_wen,
    output logic [RF_L2D-1:0]   o_raddr,
    output logic                o_ren,
    input  logic [RF_WIDTH-1:0] i_rdata
);

    localparam int unsigned N   = 32 / RF_WIDTH;
    localparam int unsigned L2N = $clog2(N);
    localparam int unsigned CW  = (L2N > 0) ? L2N : 1;
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW:0]   RCNT_N = (CW + 1)'(N);
    localparam logic [5:0]    MAXREG = 6'(31 + CSR_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wcnt;
    logic [CW:0]         r_rcnt;
    logic [CW-1:0]       r_ccnt;
    logic                r_pend;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic                w_accept;
    logic                w_bad;
    logic                w_abort;
    logic                w_wissue;
    logic                w_rissue;
    logic [RF_WIDTH-1:0] w_wword;
    logic [RF_L2D-1:0]   w_base;
    logic [RF_L2D-1:0]   w_dbg_waddr;
    logic [RF_L2D-1:0]   w_dbg_raddr;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad || (i_dbg_regnum == 6'd0)) begin
                        w_state_nxt = S_ACK;
                    end else if (i_dbg_we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_WR: begin
                if (w_abort) begin
                    w_state_nxt = S_ACK;
                end else if (w_wissue && (r_wcnt == LAST)) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_RD: begin
                if (w_abort) begin
                    w_state_nxt = S_ACK;
                end else if (r_pend && (r_ccnt == LAST)) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue is gated by i_halted combinationally so no word goes out in the abort cycle.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && i_dbg_req && i_halted;
        w_bad      = i_dbg_regnum > MAXREG;
        w_abort    = ((r_state == S_WR) || (r_state == S_RD)) && !i_halted;
        w_wissue   = (r_state == S_WR) && i_halted && !i_cpu_wen;
        w_rissue   = (r_state == S_RD) && i_halted && (r_rcnt != RCNT_N) && !i_cpu_ren;
        o_dbg_ack  = (r_state == S_ACK);
        o_dbg_err  = (r_state == S_ACK) && r_err;
        o_dbg_busy = (r_state != S_IDLE);
    end

    always_comb begin
        w_wword = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_wcnt == CW'(k)) begin
                w_wword = i_dbg_wdata[k*RF_WIDTH +: RF_WIDTH];
            end
        end
        w_base      = RF_L2D'(i_dbg_regnum) << L2N;
        w_dbg_waddr = w_base | RF_L2D'(r_wcnt);
        w_dbg_raddr = w_base | RF_L2D'(r_rcnt[CW-1:0]);

        if (i_cpu_wen) begin
            o_waddr = i_cpu_waddr;
            o_wdata = i_cpu_wdata;
            o_wen   = 1'b1;
        end else begin
            o_waddr = w_dbg_waddr;
            o_wdata = w_wword;
            o_wen   = w_wissue;
        end

        if (i_cpu_ren) begin
            o_raddr = i_cpu_raddr;
            o_ren   = 1'b1;
        end else begin
            o_raddr = w_dbg_raddr;
            o_ren   = w_rissue;
        end

        o_cpu_rdata = i_rdata;
        o_dbg_rdata = r_rdata;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_ccnt  <= '0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_pend <= w_rissue;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wcnt  <= '0;
                        r_rcnt  <= '0;
                        r_ccnt  <= '0;
                        r_err   <= w_bad;
                        r_rdata <= '0;
                    end
                end
                S_WR: begin
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end else if (w_wissue) begin
                        r_wcnt <= r_wcnt + CW'(1);
                    end
                end
                S_RD: begin
                    if (w_abort) begin
                        r_err <= 1'b1;
                    end else begin
                        if (w_rissue) begin
                            r_rcnt <= r_rcnt + (CW + 1)'(1);
                        end
                        if (r_pend) begin
                            for (int unsigned k = 0; k < N; k++) begin
                                if (r_ccnt == CW'(k)) begin
                                    r_rdata[k*RF_WIDTH +: RF_WIDTH] <= i_rdata;
                                end
                            end
                            r_ccnt <= r_ccnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
